// File: rtl/mem_access_unit_if.sv
// Request/response and memory-side signal bundle for mem_access_unit.
// The unit connects through the slave modport; the CPU/memory environment uses master.
interface mem_access_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              reqValid;
  logic [1:0]        reqOp;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqData;
  logic              reqReady;

  logic              respValid;
  logic [DATA_W-1:0] respData;
  logic              respErr;
  logic              stackFault;
  logic [ADDR_W-1:0] sp;

  logic [ADDR_W-1:0] memAddress;
  logic              memWriteEn;
  logic [DATA_W-1:0] memDataOut;
  logic [DATA_W-1:0] memDataIn;

  modport slave (
    input  reqValid, reqOp, reqAddr, reqData, memDataIn,
    output reqReady, respValid, respData, respErr, stackFault, sp,
           memAddress, memWriteEn, memDataOut
  );

  modport master (
    output reqValid, reqOp, reqAddr, reqData, memDataIn,
    input  reqReady, respValid, respData, respErr, stackFault, sp,
           memAddress, memWriteEn, memDataOut
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store/push/pop front end for a combinational-read data memory.
// One request at a time: IDLE accepts, ACCESS drives the memory, DONE pulses the response.
module mem_access_unit #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] SP_RESET    = 8'hFF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hF0
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_PUSH = 2'b10, OP_POP = 2'b11} op_t;

  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] FULL_SP = STACK_LIMIT - ONE;

  state_t            state, state_next;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] sp_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_err_q;
  logic              fault_q;

  logic              stack_full;
  logic              stack_empty;
  logic              ready;
  logic              resp_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  assign stack_full  = (sp_q == FULL_SP);
  assign stack_empty = (sp_q == SP_RESET);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    resp_valid = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        ready = !reset;
        if (bus.reqValid && !reset) state_next = ACCESS;
      end
      ACCESS: begin
        state_next = DONE;
        case (op_q)
          OP_LOAD:  mem_addr = addr_q;
          OP_STORE: begin
            mem_addr  = addr_q;
            mem_wdata = data_q;
            mem_we    = !reset;
          end
          OP_PUSH: begin
            if (!stack_full) begin
              mem_addr  = sp_q;
              mem_wdata = data_q;
              mem_we    = !reset;
            end
          end
          OP_POP: begin
            if (!stack_empty) mem_addr = sp_q + ONE;
          end
          default: ;
        endcase
      end
      DONE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the request payload needs no reset; it is always rewritten at accept before it is used.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.reqValid) begin
      op_q   <= op_t'(bus.reqOp);
      addr_q <= bus.reqAddr;
      data_q <= bus.reqData;
    end
  end

  // Stack pointer, read data and error flags all settle at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q        <= SP_RESET;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else if (state == ACCESS) begin
      case (op_q)
        OP_LOAD: begin
          resp_data_q <= bus.memDataIn;
          resp_err_q  <= 1'b0;
        end
        OP_STORE: resp_err_q <= 1'b0;
        OP_PUSH: begin
          if (stack_full) begin
            resp_err_q <= 1'b1;
            fault_q    <= 1'b1;
          end else begin
            sp_q       <= sp_q - ONE;
            resp_err_q <= 1'b0;
          end
        end
        OP_POP: begin
          if (stack_empty) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b1;
            fault_q     <= 1'b1;
          end else begin
            resp_data_q <= bus.memDataIn;
            sp_q        <= sp_q + ONE;
            resp_err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.reqReady   = ready;
  assign bus.respValid  = resp_valid;
  assign bus.respData   = resp_data_q;
  assign bus.respErr    = resp_err_q;
  assign bus.stackFault = fault_q;
  assign bus.sp         = sp_q;
  assign bus.memAddress = mem_addr;
  assign bus.memWriteEn = mem_we;
  assign bus.memDataOut = mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected responses,
// a negedge monitor pops and compares whenever respValid is seen.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_access_unit #(
    .ADDR_W(8), .DATA_W(8), .SP_RESET(8'hFF), .STACK_LIMIT(8'hF0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Memory model: initial contents are addr ^ 8'h5A, loaded on the first edge (reset is high then).
  logic [7:0] mem [256];
  bit mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem_init_done <= 1'b1;
    end else if (bus.memWriteEn) begin
      mem[bus.memAddress] <= bus.memDataOut;
    end
  end
  assign bus.memDataIn = mem[bus.memAddress];

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [7:0] sp;
    logic       fault;
    int         we;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int we_cnt = 0;

  logic [7:0] last_rd;
  logic [7:0] exp_sp;
  logic       exp_fault;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle counter, accept timestamp and write-enable count per request.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && bus.reqValid && bus.reqReady) begin
      accept_cyc <= cyc;
      we_cnt     <= 0;
    end else if (bus.memWriteEn) begin
      we_cnt <= we_cnt + 1;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (bus.respValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got respValid=1 expected no response (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_data",    bus.respData,     mon_e.data);
        check("resp_err",     bus.respErr,      mon_e.err);
        check("resp_sp",      bus.sp,           mon_e.sp);
        check("resp_fault",   bus.stackFault,   mon_e.fault);
        check("latency",      cyc - accept_cyc, 2);
        check("write_cycles", we_cnt,           mon_e.we);
      end
    end
  end

  task automatic push_exp(logic [7:0] data, logic err, int we);
    exp_t e;
    e.data  = data;
    e.err   = err;
    e.sp    = exp_sp;
    e.fault = exp_fault;
    e.we    = we;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.reqReady && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.reqReady) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got reqReady=0 expected 1 within 10 cycles");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic issue(logic [1:0] op, logic [7:0] addr, logic [7:0] data,
                       logic [7:0] e_data, logic e_err, int e_we);
    wait_ready();
    bus.reqValid = 1'b1;
    bus.reqOp    = op;
    bus.reqAddr  = addr;
    bus.reqData  = data;
    push_exp(e_data, e_err, e_we);
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    wait_drain();
  endtask

  task automatic do_load(logic [7:0] addr, logic [7:0] data);
    last_rd = data;
    issue(2'b00, addr, 8'h00, data, 1'b0, 0);
  endtask

  task automatic do_store(logic [7:0] addr, logic [7:0] data);
    issue(2'b01, addr, data, last_rd, 1'b0, 1);
  endtask

  task automatic do_push(logic [7:0] data, logic [7:0] sp_after, logic err);
    exp_sp = sp_after;
    if (err) exp_fault = 1'b1;
    issue(2'b10, 8'h00, data, last_rd, err, err ? 0 : 1);
  endtask

  task automatic do_pop(logic [7:0] data, logic [7:0] sp_after, logic err);
    exp_sp  = sp_after;
    last_rd = data;
    if (err) exp_fault = 1'b1;
    issue(2'b11, 8'h00, 8'h00, data, err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.reqValid = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.reqReady, 1'b0);
    check("rst_we",    bus.memWriteEn, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    exp_sp = 8'hFF;
    exp_fault = 1'b0;
    last_rd = 8'h00;
    exp_q.delete();
    @(negedge clk);
    check("idle_ready",     bus.reqReady,   1'b1);
    check("idle_sp",        bus.sp,         8'hFF);
    check("idle_respvalid", bus.respValid,  1'b0);
    check("idle_fault",     bus.stackFault, 1'b0);
    check("idle_we",        bus.memWriteEn, 1'b0);
    check("idle_respdata",  bus.respData,   8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int prev;
    bus.reqValid = 1'b0;
    bus.reqOp    = 2'b00;
    bus.reqAddr  = 8'h00;
    bus.reqData  = 8'h00;
    last_rd   = 8'h00;
    exp_sp    = 8'hFF;
    exp_fault = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic store then load.
    do_store(8'h10, 8'hA5);
    do_load(8'h10, 8'hA5);

    // Small push/pop round trip.
    do_push(8'h11, 8'hFE, 1'b0);
    do_push(8'h22, 8'hFD, 1'b0);
    do_pop(8'h22, 8'hFE, 1'b0);
    do_pop(8'h11, 8'hFF, 1'b0);
    do_load(8'hFF, 8'h11);

    // Fill the 16-entry stack, then overflow once.
    for (int i = 0; i < 16; i++) do_push(8'h30 + 8'(i), 8'hFE - 8'(i), 1'b0);
    do_push(8'hEE, 8'hEF, 1'b1);
    do_load(8'hEF, 8'hB5);

    // Drain in LIFO order.
    for (int k = 0; k < 16; k++) do_pop(8'h3F - 8'(k), 8'hF0 + 8'(k), 1'b0);

    // Underflow from a fresh reset, then normal traffic with the sticky flag set.
    do_reset();
    do_pop(8'h00, 8'hFF, 1'b1);
    do_push(8'h99, 8'hFE, 1'b0);
    do_pop(8'h99, 8'hFF, 1'b0);

    // Throughput: reqValid held high, LOAD 8'h10 accepted once every three cycles.
    @(negedge clk);
    bus.reqValid = 1'b1;
    bus.reqOp    = 2'b00;
    bus.reqAddr  = 8'h10;
    bus.reqData  = 8'h00;
    last_rd = 8'hA5;
    acc  = 0;
    prev = 0;
    for (int n = 0; n < 9; n++) begin
      if (bus.reqReady) begin
        push_exp(8'hA5, 1'b0, 0);
        if (acc > 0) check("accept_spacing", cyc - prev, 3);
        prev = cyc;
        acc++;
      end
      @(negedge clk);
    end
    bus.reqValid = 1'b0;
    check("accept_count", acc, 3);
    wait_drain();

    // Reset during the ACCESS cycle of a STORE to 8'h20.
    wait_ready();
    bus.reqValid = 1'b1;
    bus.reqOp    = 2'b01;
    bus.reqAddr  = 8'h20;
    bus.reqData  = 8'h77;
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("access_rst_we", bus.memWriteEn, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_sp = 8'hFF;
    exp_fault = 1'b0;
    last_rd = 8'h00;
    @(negedge clk);
    check("post_rst_ready", bus.reqReady,   1'b1);
    check("post_rst_sp",    bus.sp,         8'hFF);
    check("post_rst_resp",  bus.respValid,  1'b0);
    check("post_rst_fault", bus.stackFault, 1'b0);
    repeat (3) @(negedge clk);
    do_load(8'h20, 8'h7A);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front end sitting directly upstream of the 256x8 data memory. Accepts one memory request at a time from the CPU control path: LOAD, STORE, PUSH or POP. It owns the stack pointer and drives the memory's address, write-enable and write-data inputs. It captures the memory's combinational read data and returns it with a single-cycle response pulse.

Parameters:
ADDR_W, 8, memory address width (256 bytes)
DATA_W, 8, data width
SP_RESET, 8'hFF, stack pointer value after reset (empty stack); stack grows downward
STACK_LIMIT, 8'hF0, lowest legal stack address; constraint 1 <= STACK_LIMIT <= SP_RESET

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
reqValid  in  1  request present
reqOp  in  2  00 LOAD, 01 STORE, 10 PUSH, 11 POP
reqAddr  in  ADDR_W  LOAD/STORE address (ignored for PUSH/POP)
reqData  in  DATA_W  STORE/PUSH data
reqReady  out  1  unit can accept a request this cycle
respValid  out  1  one-cycle pulse, request complete
respData  out  DATA_W  LOAD/POP result, held until next LOAD/POP completes
respErr  out  1  valid with respValid: stack overflow/underflow on this request
stackFault  out  1  sticky fault flag, cleared only by reset
sp  out  ADDR_W  current stack pointer (next free slot)
memAddress  out  ADDR_W  to memory address
memWriteEn  out  1  to memory write enable
memDataOut  out  DATA_W  to memory data input
memDataIn  in  DATA_W  from memory data output (combinational read)

Behaviour:
- Reset (synchronous, any state): state=IDLE, sp=SP_RESET, respValid=0, respData=0, respErr=0, stackFault=0. Any in-flight request is discarded.
- memWriteEn is gated by !reset, so no write occurs in a reset cycle.
- FSM states are IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - reqReady = !reset.
  - On reqValid && reqReady, latch op, addr and data, then go to ACCESS.
- ACCESS:
  - reqReady=0.
  - Drive memAddress/memWriteEn/memDataOut per op.
  - Stack pointer updates and respData capture happen at the end of this cycle.
  - Next state is DONE.
- DONE:
  - respValid=1 for exactly this cycle, respErr valid.
  - reqReady=0. Next state is IDLE.
- Throughput: one request per 3 cycles. Response appears 2 cycles after the accept edge.
- Outside ACCESS: memAddress=0, memWriteEn=0, memDataOut=0.
- LOAD: memAddress=addr; respData<=memDataIn; respErr=0.
- STORE: memAddress=addr, memDataOut=data, memWriteEn=1; respData unchanged.
- PUSH, not full: memAddress=sp, memDataOut=data, memWriteEn=1; sp<=sp-1.
- PUSH, full (sp==STACK_LIMIT-1): memWriteEn=0, sp unchanged, respErr=1, stackFault<=1.
- POP, not empty: memAddress=sp+1; respData<=memDataIn; sp<=sp+1.
- POP, empty (sp==SP_RESET): sp unchanged, respData<=0, respErr=1, stackFault<=1.
- Capacity is SP_RESET-STACK_LIMIT+1 entries (16 at defaults).
- sp arithmetic is modulo 2^ADDR_W, but the full/empty checks prevent sp leaving [STACK_LIMIT-1, SP_RESET].
- LOAD/STORE may address the stack region without affecting sp.
- reqValid is ignored outside IDLE: no queuing, the requester must hold the request until reqReady.
- Reset asserted during ACCESS: no write commits, sp returns to SP_RESET, no respValid is produced.

Test Plan:
- Reset then idle -> reqReady=1, sp=8'hFF, respValid=0, stackFault=0, memWriteEn=0.
- STORE addr=8'h10 data=8'hA5, then LOAD addr=8'h10 -> memWriteEn high exactly one cycle (ACCESS); LOAD respValid pulse with respData=8'hA5, respErr=0; accept-to-respValid = 2 cycles.
- PUSH 8'h11, PUSH 8'h22, POP, POP -> sp goes FF->FE->FD->FE->FF; POPs return 8'h22 then 8'h11; LOAD 8'hFF returns 8'h11.
- 16 PUSHes then a 17th -> sp=8'hEF after 16; 17th gives respErr=1, stackFault=1, no write, sp stays 8'hEF; a following LOAD 8'hEF still returns its pre-test value.
- POP on empty stack -> respData=0, respErr=1, stackFault=1, sp=8'hFF. A later valid PUSH/POP gives respErr=0, stackFault stays 1.
- reqValid held high continuously -> accepts only every third cycle. Reset asserted during ACCESS of a STORE to 8'h20 -> no write, state IDLE next cycle, no respValid.
